pc_halt_sequencer: RTL and testbench



---
 rtl/pc_halt_sequencer.sv | 118 +++++++++++
 tb/tb_pc_halt_sequencer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/pc_halt_sequencer.sv
// pc_halt_sequencer
//   Program-counter sequencer and HALT controller for the single-cycle 16-bit
//   processor. It drives the instruction-memory byte address and watches the
//   fetched word for the HALT encoding. On HALT the PC freezes and commit is
//   suppressed until a rising edge on GO, which then steps past the HALT.
//   Every architectural write (register file, data memory, IO) is gated by
//   COMMIT.
//
// Optional build macro: SINGLE_STEP_EN
//   When it is defined, the STEP_MODE input and the STEP_WAIT state are added.
//   With STEP_MODE=1, each non-HALT instruction commits, the PC advances, and
//   the sequencer then parks until the next GO rise.
//
// Ports:
//   CLK        in   1        system clock, rising edge
//   RESET      in   1        synchronous, active-high reset
//   INSTR      in   INSTR_W  instruction fetched at PC (combinational read)
//   BR_TAKEN   in   1        non-sequential next PC requested
//   BR_TARGET  in   ADDR_W   branch byte address (bit 0 forced to 0)
//   GO         in   1        resume request level (already synchronised)
//   STEP_MODE  in   1        single-step enable (SINGLE_STEP_EN only)
//   PC         out  ADDR_W   current instruction byte address
//   COMMIT     out  1        current instruction may write state
//   HALTED     out  1        sequencer is stopped
//   HALT_CNT   out  8        HALTs executed, saturating at 255
module pc_halt_sequencer #(
  parameter int unsigned          ADDR_W  = 8,
  parameter int unsigned          INSTR_W = 16,
  parameter logic [INSTR_W-1:0]   HALT_OP = 16'h0001,
  parameter int unsigned          PC_INC  = 2
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [INSTR_W-1:0] INSTR,
  input  logic               BR_TAKEN,
  input  logic [ADDR_W-1:0]  BR_TARGET,
  input  logic               GO,
`ifdef SINGLE_STEP_EN
  input  logic               STEP_MODE,
`endif
  output logic [ADDR_W-1:0]  PC,
  output logic               COMMIT,
  output logic               HALTED,
  output logic [7:0]         HALT_CNT
);

`ifdef SINGLE_STEP_EN
  typedef enum logic [1:0] {RUN, HALT_WAIT, STEP_WAIT} state_t;
`else
  typedef enum logic [1:0] {RUN, HALT_WAIT} state_t;
`endif

  localparam logic [ADDR_W-1:0] INC = ADDR_W'(PC_INC);

  state_t              state;
  logic                go_q;
  logic                go_rise;
  logic                is_halt;
  logic [ADDR_W-1:0]   pc_seq;
  logic [ADDR_W-1:0]   pc_next;

  // Compare all 16 bits, so opcodes that only overlap HALT's bits do not halt.
  assign is_halt = (INSTR == HALT_OP);

  // A GO level that is held produces exactly one rise. go_q is registered
  // in every state, so a press during the HALT fetch cycle is used up there
  // and cannot resume. The operator must release GO and press it again.
  assign go_rise = GO & ~go_q;

  // Wraps modulo 2^ADDR_W, so 8'hFE + 2 gives 8'h00.
  assign pc_seq  = PC + INC;
  assign pc_next = BR_TAKEN ? {BR_TARGET[ADDR_W-1:1], 1'b0} : pc_seq;

  // Decode of the state plus the current fetch. Both outputs are forced low
  // while RESET is high.
  assign COMMIT = ~RESET & (state == RUN) & ~is_halt;
  assign HALTED = ~RESET & (state != RUN);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= RUN;
      PC       <= '0;
      HALT_CNT <= '0;
      go_q     <= 1'b0;
    end else begin
      go_q <= GO;
      case (state)
        RUN: begin
          if (is_halt) begin
            // Hold the PC at the HALT and ignore any branch request.
            state <= HALT_WAIT;
            if (HALT_CNT != 8'hFF) HALT_CNT <= HALT_CNT + 8'd1;
          end else begin
            PC <= pc_next;
`ifdef SINGLE_STEP_EN
            if (STEP_MODE) state <= STEP_WAIT;
`endif
          end
        end
        HALT_WAIT: begin
          // Resume steps past the HALT word.
          if (go_rise) begin
            PC    <= pc_seq;
            state <= RUN;
          end
        end
`ifdef SINGLE_STEP_EN
        STEP_WAIT: begin
          // The PC already advanced when the stepped instruction committed.
          if (go_rise) state <= RUN;
        end
`endif
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_halt_sequencer.sv
// Directed bench for pc_halt_sequencer in its default build (SINGLE_STEP_EN
// undefined). Inputs change 2 time units after a rising edge. Outputs are
// sampled 1 unit after that, well away from the next edge.
module tb_pc_halt_sequencer;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [15:0] INSTR;
  logic        BR_TAKEN;
  logic [7:0]  BR_TARGET;
  logic        GO;
  logic [7:0]  PC;
  logic        COMMIT;
  logic        HALTED;
  logic [7:0]  HALT_CNT;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [15:0] HALT = 16'h0001;
  localparam logic [15:0] NOP  = 16'h1234;

  pc_halt_sequencer dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .INSTR     (INSTR),
    .BR_TAKEN  (BR_TAKEN),
    .BR_TARGET (BR_TARGET),
    .GO        (GO),
    .PC        (PC),
    .COMMIT    (COMMIT),
    .HALTED    (HALTED),
    .HALT_CNT  (HALT_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp)
      else begin
        miscompares++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // Checks all four outputs in one call.
  task automatic chk_all(input string tag, input logic [7:0] pc, input logic cm,
                         input logic hl, input logic [7:0] cnt);
    #1;
    chk({tag, ".pc"},     {8'h0, PC},       {8'h0, pc});
    chk({tag, ".commit"}, {15'h0, COMMIT},  {15'h0, cm});
    chk({tag, ".halted"}, {15'h0, HALTED},  {15'h0, hl});
    chk({tag, ".cnt"},    {8'h0, HALT_CNT}, {8'h0, cnt});
  endtask

  initial begin
    RESET = 1'b1; INSTR = NOP; BR_TAKEN = 1'b0; BR_TARGET = 8'h00; GO = 1'b0;
    tick(); tick();
    chk_all("reset", 8'h00, 1'b0, 1'b0, 8'd0);

    // Sequential run, PC 0,2,4,6,8
    RESET = 1'b0;
    chk_all("run0", 8'h00, 1'b1, 1'b0, 8'd0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk_all("run", 8'(2*i), 1'b1, 1'b0, 8'd0);
    end

    // HALT at PC 8
    INSTR = HALT;
    chk_all("haltfetch", 8'h08, 1'b0, 1'b0, 8'd0);
    tick();
    chk_all("halt8", 8'h08, 1'b0, 1'b1, 8'd1);

    // GO held for 5 cycles gives one resume. The HALT word stays on the bus,
    // so the sequencer halts again at 10 and the held GO cannot release it.
    GO = 1'b1;
    tick();
    chk_all("resume10", 8'h0A, 1'b0, 1'b0, 8'd1);
    tick();
    chk_all("rehalt10", 8'h0A, 1'b0, 1'b1, 8'd2);
    tick(); tick(); tick();
    chk_all("goheld", 8'h0A, 1'b0, 1'b1, 8'd2);
    GO = 1'b0;
    tick();
    chk_all("gorel", 8'h0A, 1'b0, 1'b1, 8'd2);
    GO = 1'b1;
    tick();
    chk_all("resume12", 8'h0C, 1'b0, 1'b0, 8'd2);

    // 16'h0011 overlaps HALT's bit 0 but is not HALT
    GO = 1'b0; INSTR = 16'h0011;
    chk_all("nearhalt", 8'h0C, 1'b1, 1'b0, 8'd2);
    tick();
    chk_all("nearhalt+", 8'h0E, 1'b1, 1'b0, 8'd2);

    // Branch to 0x23 lands at 0x22
    BR_TAKEN = 1'b1; BR_TARGET = 8'h23;
    tick();
    chk_all("branch", 8'h22, 1'b1, 1'b0, 8'd2);

    // A branch that coincides with a HALT is ignored
    BR_TARGET = 8'h40; INSTR = HALT;
    chk_all("brhalt", 8'h22, 1'b0, 1'b0, 8'd2);
    tick();
    chk_all("brhalt+", 8'h22, 1'b0, 1'b1, 8'd3);
    BR_TAKEN = 1'b0; GO = 1'b1;
    tick();
    chk_all("resume24", 8'h24, 1'b0, 1'b0, 8'd3);

    // Wrap: HALT at 0xFE, resume goes to 0x00
    GO = 1'b0; INSTR = NOP; BR_TAKEN = 1'b1; BR_TARGET = 8'hFE;
    tick();
    chk_all("toFE", 8'hFE, 1'b1, 1'b0, 8'd3);
    BR_TAKEN = 1'b0; INSTR = HALT;
    tick();
    chk_all("haltFE", 8'hFE, 1'b0, 1'b1, 8'd4);
    GO = 1'b1;
    tick();
    chk_all("wrap", 8'h00, 1'b0, 1'b0, 8'd4);

    // A GO rise in the same cycle the HALT is fetched is ignored
    GO = 1'b0; INSTR = NOP;
    tick();
    chk_all("pre", 8'h02, 1'b1, 1'b0, 8'd4);
    INSTR = HALT; GO = 1'b1;
    tick();
    chk_all("gowithhalt", 8'h02, 1'b0, 1'b1, 8'd5);
    tick();
    chk_all("gowithhalt+", 8'h02, 1'b0, 1'b1, 8'd5);
    GO = 1'b0;
    tick();
    GO = 1'b1;
    tick();
    chk_all("resume04", 8'h04, 1'b0, 1'b0, 8'd5);

    // Reset while in HALT_WAIT
    GO = 1'b0;
    tick();
    chk_all("halt04", 8'h04, 1'b0, 1'b1, 8'd6);
    RESET = 1'b1;
    chk_all("rstmid", 8'h04, 1'b0, 1'b0, 8'd6);
    tick();
    chk_all("rsthalt", 8'h00, 1'b0, 1'b0, 8'd0);
    RESET = 1'b0; INSTR = NOP;
    chk_all("postrst", 8'h00, 1'b1, 1'b0, 8'd0);

    // 256 HALT/resume pairs: the count saturates and PC wraps back to 0
    INSTR = HALT;
    for (int i = 0; i < 256; i++) begin
      GO = 1'b0;
      tick();
      if (i == 254) chk_all("cnt255", 8'hFC, 1'b0, 1'b1, 8'd255);
      GO = 1'b1;
      tick();
    end
    chk_all("saturate", 8'h00, 1'b0, 1'b0, 8'd255);
    GO = 1'b0;
    tick();
    chk_all("saturate+", 8'h00, 1'b0, 1'b1, 8'd255);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
